// File: rtl/whack_event_sequencer.sv
// Round-robin arbiter for per-hole press/expiry requests. Classifies one granted
// request per cycle as miss / partial hit / full-clear hit and applies a post-miss lockout.
module whack_event_sequencer #(
    parameter int N_HOLES        = 8,
    parameter int LOCKOUT_CYCLES = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               game_active,
    input  logic [N_HOLES-1:0] btn_press,
    input  logic [N_HOLES-1:0] mole_up,
    input  logic [N_HOLES-1:0] mole_expire,
    output logic               miss,
    output logic               non_full_clear_hit,
    output logic               full_clear_hit,
    output logic [N_HOLES-1:0] mole_clear,
    output logic               lockout,
    output logic               pending
);

    localparam int PW = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LW-1:0] LOCK_LAST = (LOCKOUT_CYCLES > 0) ? LW'(LOCKOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LOCK} state_t;

    state_t             state_reg, state_next;
    logic [N_HOLES-1:0] pend_press_reg, pend_press_next;
    logic [N_HOLES-1:0] pend_exp_reg, pend_exp_next;
    logic [N_HOLES-1:0] shadow_reg, shadow_next;
    logic [PW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [LW-1:0]      lock_cnt_reg, lock_cnt_next;
    logic               miss_reg, miss_next;
    logic               nfc_reg, nfc_next;
    logic               fc_reg, fc_next;
    logic [N_HOLES-1:0] clear_reg, clear_next;
    logic               pending_reg, pending_next;

    logic [N_HOLES-1:0] request;
    logic [N_HOLES-1:0] live;
    logic [N_HOLES-1:0] grant_onehot;
    logic [PW-1:0]      grant_idx;
    logic               grant_found;
    logic [PW:0]        scan_idx;
    logic [PW:0]        ptr_inc;
    logic               is_press;
    logic               is_live;
    logic               one_live;

    // A hole already cleared but still shown up by the spawner must not count as live.
    generate
        for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_live
            assign live[gi]    = mole_up[gi] & ~shadow_reg[gi];
            assign request[gi] = pend_press_reg[gi] | pend_exp_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            pend_press_reg <= '0;
            pend_exp_reg   <= '0;
            shadow_reg     <= '0;
            rr_ptr_reg     <= '0;
            lock_cnt_reg   <= '0;
            miss_reg       <= 1'b0;
            nfc_reg        <= 1'b0;
            fc_reg         <= 1'b0;
            clear_reg      <= '0;
            pending_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pend_press_reg <= pend_press_next;
            pend_exp_reg   <= pend_exp_next;
            shadow_reg     <= shadow_next;
            rr_ptr_reg     <= rr_ptr_next;
            lock_cnt_reg   <= lock_cnt_next;
            miss_reg       <= miss_next;
            nfc_reg        <= nfc_next;
            fc_reg         <= fc_next;
            clear_reg      <= clear_next;
            pending_reg    <= pending_next;
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_HOLES; k++) begin
            scan_idx = {1'b0, rr_ptr_reg} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(N_HOLES))
                scan_idx = scan_idx - (PW+1)'(N_HOLES);
            if (!grant_found && request[scan_idx[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[PW-1:0];
            end
        end
        grant_onehot = grant_found ? (N_HOLES'(1) << grant_idx) : '0;
        ptr_inc = {1'b0, grant_idx} + (PW+1)'(1);
        if (ptr_inc >= (PW+1)'(N_HOLES))
            ptr_inc = '0;
        is_press = pend_press_reg[grant_idx];
        is_live  = live[grant_idx];
        one_live = ($countones(live) == 1);
    end

    always_comb begin
        state_next      = state_reg;
        pend_press_next = '0;
        pend_exp_next   = '0;
        shadow_next     = '0;
        rr_ptr_next     = rr_ptr_reg;
        lock_cnt_next   = '0;
        miss_next       = 1'b0;
        nfc_next        = 1'b0;
        fc_next         = 1'b0;
        clear_next      = '0;
        pending_next    = 1'b0;

        if (!game_active) begin
            state_next = ST_IDLE;
        end else if (state_reg == ST_IDLE) begin
            state_next = ST_RUN;
        end else begin
            pending_next = |request;
            if (grant_found) begin
                rr_ptr_next = ptr_inc[PW-1:0];
                // A press wins over a simultaneous expiry; a dead expiry is dropped.
                miss_next = is_press ^ is_live;
                nfc_next  = is_press & is_live & ~one_live;
                fc_next   = is_press & is_live & one_live;
                if (is_live)
                    clear_next = grant_onehot;
            end
            pend_press_next = (pend_press_reg & ~grant_onehot) |
                              ((state_reg == ST_RUN) ? btn_press : '0);
            pend_exp_next   = (pend_exp_reg & ~grant_onehot) | mole_expire;
            shadow_next     = clear_next | (shadow_reg & mole_up);
            lock_cnt_next   = lock_cnt_reg;

            if (miss_next && (LOCKOUT_CYCLES > 0)) begin
                state_next    = ST_LOCK;
                lock_cnt_next = '0;
            end else if (state_reg == ST_LOCK) begin
                if (lock_cnt_reg == LOCK_LAST) begin
                    state_next    = ST_RUN;
                    lock_cnt_next = '0;
                end else begin
                    lock_cnt_next = lock_cnt_reg + LW'(1);
                end
            end
        end
    end

    assign miss               = miss_reg;
    assign non_full_clear_hit = nfc_reg;
    assign full_clear_hit     = fc_reg;
    assign mole_clear         = clear_reg;
    assign lockout            = (state_reg == ST_LOCK);
    assign pending            = pending_reg;

endmodule
